// File: rtl/axis_ema_pkg.sv
// Shared types, constants and the EMA arithmetic for the multi-channel EMA scheduler.
package axis_ema_pkg;

    // Scheduler control states: waiting for a request, or streaming a granted packet.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_state_t;

    // Reset/clear value of every channel's filter state.
    localparam int unsigned DEFAULT_INIT_Y = 1000;

    // Widest sample the helper handles; callers zero-extend and truncate back.
    localparam int EMA_MAX_W = 64;

    // One EMA step: x/4 + y/4 + y/2 with truncating shifts.
    // Right shifts commute with zero-extension, so evaluating at 64 bits and
    // truncating gives exactly the DATA_W-bit result.
    function automatic logic [EMA_MAX_W-1:0] ema_step(
        input logic [EMA_MAX_W-1:0] x,
        input logic [EMA_MAX_W-1:0] y
    );
        return (x >> 2) + (y >> 2) + (y >> 1);
    endfunction

endpackage

// File: rtl/axis_ema_sched_rr_arbiter.sv
// Round-robin priority picker: first requesting channel at or after ptr, modulo NUM_CH.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    // w_cand[k] is the channel examined at priority k (k = 0 is highest).
    logic [CH_W-1:0] w_cand [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign w_cand[gi] = CH_W'((int'(ptr) + gi) % NUM_CH);
        end
    endgenerate

    // Scan from lowest to highest priority so the highest-priority requester lands last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                gnt_any = 1'b1;
                gnt_idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/axis_ema_sched.sv
// Packet-granular round-robin scheduler sharing one EMA datapath among NUM_CH
// AXI-Stream channels, with per-channel filter state and a TID-tagged output stream.
module axis_ema_sched
    import axis_ema_pkg::fsm_state_t, axis_ema_pkg::ema_step,
           axis_ema_pkg::DEFAULT_INIT_Y, axis_ema_pkg::EMA_MAX_W;
#(
    parameter  int          NUM_CH = 4,
    parameter  int          DATA_W = 32,
    parameter  int unsigned INIT_Y = DEFAULT_INIT_Y,
    localparam int          CH_W   = $clog2(NUM_CH)
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NUM_CH*DATA_W-1:0] S_AXIS_TDATA,
    input  logic [NUM_CH*4-1:0]      S_AXIS_TKEEP,
    input  logic [NUM_CH-1:0]        S_AXIS_TLAST,
    input  logic [NUM_CH-1:0]        S_AXIS_TVALID,
    output logic [NUM_CH-1:0]        S_AXIS_TREADY,
    output logic [DATA_W-1:0]        M_AXIS_TDATA,
    output logic [3:0]               M_AXIS_TKEEP,
    output logic                     M_AXIS_TLAST,
    output logic [CH_W-1:0]          M_AXIS_TID,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY,
    input  logic [NUM_CH-1:0]        CH_CLEAR,
    output logic                     BUSY,
    output logic [CH_W-1:0]          GRANT
);

    fsm_state_t        r_state;
    fsm_state_t        w_state_next;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0] r_y [NUM_CH];

    logic [DATA_W-1:0] r_m_tdata;
    logic [3:0]        r_m_tkeep;
    logic              r_m_tlast;
    logic [CH_W-1:0]   r_m_tid;
    logic              r_m_tvalid;

    logic              w_arb_any;
    logic [CH_W-1:0]   w_arb_idx;
    logic              w_out_free;
    logic              w_busy;
    logic              w_accept;
    logic              w_last_accept;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y_new;
    logic [3:0]        w_keep;
    logic              w_last;
    logic [NUM_CH-1:0] w_s_tready;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req     (S_AXIS_TVALID),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_arb_idx),
        .gnt_any (w_arb_any)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign w_out_free    = !r_m_tvalid || M_AXIS_TREADY;
    assign w_busy        = (r_state == axis_ema_pkg::BUSY);
    assign w_accept      = w_busy && S_AXIS_TVALID[r_grant] && w_out_free;
    assign w_x           = S_AXIS_TDATA[int'(r_grant)*DATA_W +: DATA_W];
    assign w_keep        = S_AXIS_TKEEP[int'(r_grant)*4 +: 4];
    assign w_last        = S_AXIS_TLAST[r_grant];
    assign w_last_accept = w_accept && w_last;
    assign w_y_new       = DATA_W'(ema_step(EMA_MAX_W'(w_x), EMA_MAX_W'(r_y[r_grant])));

    // Next-state logic and per-channel ready; only the granted channel may ever be ready.
    always_comb begin
        w_state_next = r_state;
        w_s_tready   = '0;
        case (r_state)
            axis_ema_pkg::IDLE: begin
                if (w_arb_any) begin
                    w_state_next = axis_ema_pkg::BUSY;
                end
            end
            axis_ema_pkg::BUSY: begin
                w_s_tready[r_grant] = w_out_free;
                if (w_last_accept) begin
                    w_state_next = axis_ema_pkg::IDLE;
                end
            end
            default: begin
                w_state_next = axis_ema_pkg::IDLE;
            end
        endcase
    end

    // FSM state, grant latch (held through IDLE) and round-robin pointer advance on packet end.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= axis_ema_pkg::IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == axis_ema_pkg::IDLE && w_arb_any) begin
                r_grant <= w_arb_idx;
            end
            if (w_last_accept) begin
                r_rr_ptr <= (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_y
            // Per-channel filter state; a clear overrides a same-cycle update.
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    r_y[gi] <= DATA_W'(INIT_Y);
                end else if (CH_CLEAR[gi]) begin
                    r_y[gi] <= DATA_W'(INIT_Y);
                end else if (w_accept && r_grant == CH_W'(gi)) begin
                    r_y[gi] <= w_y_new;
                end
            end
        end
    endgenerate

    // Output register: load on accept, hold while stalled, drop valid once drained.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_y_new;
            r_m_tkeep  <= w_keep;
            r_m_tlast  <= w_last;
            r_m_tid    <= r_grant;
        end else if (M_AXIS_TREADY) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign S_AXIS_TREADY = w_s_tready;
    assign M_AXIS_TDATA  = r_m_tdata;
    assign M_AXIS_TKEEP  = r_m_tkeep;
    assign M_AXIS_TLAST  = r_m_tlast;
    assign M_AXIS_TID    = r_m_tid;
    assign M_AXIS_TVALID = r_m_tvalid;
    assign BUSY          = w_busy;
    assign GRANT         = r_grant;

endmodule
